// File: rtl/pwm_capture.sv
// pwm_capture: measures the period, high time, frequency and duty cycle of an external PWM input.
// A capture FSM times the edges. A compute FSM turns each snapshot into results using one shared divider.
module pwm_capture #(
   parameter logic [31:0] CLK_HZ  = 32'd50_000_000,
   parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [23:0] period_cyc,
   output logic [23:0] high_cyc,
   output logic [23:0] freq_hz,
   output logic [6:0]  duty_pct,
   output logic        meas_done,
   output logic        sig_valid,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} cap_state_t;
   typedef enum logic [2:0] {C_IDLE, C_LOAD, C_FREQ, C_DUTY, C_WRITE} cmp_state_t;

   // sync[1:0] is the two-flop synchronizer and sync[2] is the history flop.
   // Rising and falling edges therefore have the same latency.
   logic [2:0] sync;
   logic       rise;
   logic       fall;

   // NOTE: sequential state always uses non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], pwm_in};
   end

   assign rise = sync[1] & ~sync[2];
   assign fall = ~sync[1] & sync[2];

   cap_state_t  cap_state;
   logic [23:0] per_cnt;
   logic [23:0] high_cnt;
   logic        timeout;
   logic        snap;

   assign timeout = (cap_state != S_IDLE) && (per_cnt == TIMEOUT);
   assign snap    = (cap_state == S_LOW) && !timeout && rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_state <= S_IDLE;
         per_cnt   <= '0;
         high_cnt  <= '0;
      end else if (timeout) begin
         cap_state <= S_IDLE;
      end else begin
         case (cap_state)
            S_IDLE: if (rise) begin
               cap_state <= S_HIGH;
               per_cnt   <= 24'd1;
               high_cnt  <= 24'd1;
            end
            S_HIGH: begin
               per_cnt <= per_cnt + 24'd1;
               if (fall) cap_state <= S_LOW;
               else      high_cnt  <= high_cnt + 24'd1;
            end
            S_LOW: if (rise) begin
               cap_state <= S_HIGH;
               per_cnt   <= 24'd1;
               high_cnt  <= 24'd1;
            end else begin
               per_cnt <= per_cnt + 24'd1;
            end
            default: cap_state <= S_IDLE;
         endcase
      end
   end

   // Restoring divider: dq shifts the dividend out at the top and the quotient in at the bottom.
   cmp_state_t  cmp_state;
   logic [31:0] dq;
   logic [23:0] rem;
   logic [23:0] divisor;
   logic [23:0] snap_high;
   logic [23:0] freq_q;
   logic [4:0]  bit_cnt;
   logic [24:0] rem_sh;
   logic [24:0] diff;
   logic        q_bit;
   logic [23:0] rem_next;
   logic [31:0] q_next;
   logic [31:0] duty_dividend;

   // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
   always_comb begin
      rem_sh   = {rem, dq[31]};
      diff     = rem_sh - {1'b0, divisor};
      q_bit    = !diff[24];
      rem_next = q_bit ? diff[23:0] : rem_sh[23:0];
      q_next   = {dq[30:0], q_bit};
   end

   assign duty_dividend = 32'(snap_high) * 32'd100;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_state  <= C_IDLE;
         dq         <= '0;
         rem        <= '0;
         divisor    <= '0;
         snap_high  <= '0;
         freq_q     <= '0;
         bit_cnt    <= '0;
         period_cyc <= '0;
         high_cyc   <= '0;
         freq_hz    <= '0;
         duty_pct   <= '0;
         meas_done  <= 1'b0;
         sig_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         meas_done <= 1'b0;
         overrun   <= snap && (cmp_state != C_IDLE);
         if (timeout) begin
            cmp_state  <= C_IDLE;
            period_cyc <= '0;
            high_cyc   <= '0;
            freq_hz    <= '0;
            duty_pct   <= '0;
            sig_valid  <= 1'b0;
         end else begin
            case (cmp_state)
               C_IDLE: if (snap) begin
                  divisor   <= per_cnt;
                  snap_high <= high_cnt;
                  cmp_state <= C_LOAD;
               end
               C_LOAD: begin
                  dq        <= CLK_HZ;
                  rem       <= '0;
                  bit_cnt   <= '0;
                  cmp_state <= C_FREQ;
               end
               C_FREQ: begin
                  dq      <= q_next;
                  rem     <= rem_next;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd31) begin
                     freq_q    <= q_next[23:0];
                     dq        <= duty_dividend;
                     rem       <= '0;
                     cmp_state <= C_DUTY;
                  end
               end
               C_DUTY: begin
                  dq      <= q_next;
                  rem     <= rem_next;
                  bit_cnt <= bit_cnt + 5'd1;
                  // Results are loaded on entry to C_WRITE, so they are visible in the same cycle as meas_done.
                  if (bit_cnt == 5'd31) begin
                     period_cyc <= divisor;
                     high_cyc   <= snap_high;
                     freq_hz    <= freq_q;
                     duty_pct   <= q_next[6:0];
                     meas_done  <= 1'b1;
                     sig_valid  <= 1'b1;
                     cmp_state  <= C_WRITE;
                  end
               end
               C_WRITE: cmp_state <= C_IDLE;
               default: cmp_state <= C_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a PWM generator feeds the DUT.
// A timing and arithmetic model predicts every meas_done, every overrun and every result value.
module tb_pwm_capture;

   // The clock is scaled down from 50 MHz so the long-period cases fit a short run.
   // 200 Hz becomes 5000 cycles and 1 kHz becomes 1000 cycles.
   localparam logic [31:0] CLK_HZ  = 32'd1_000_000;
   localparam logic [23:0] TIMEOUT = 24'd8000;
   // Latency from the pwm_in rising edge to meas_done: 2 synchronizer cycles, then 66 compute cycles.
   localparam int LAT = 68;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pwm_in;
   logic [23:0] period_cyc;
   logic [23:0] high_cyc;
   logic [23:0] freq_hz;
   logic [6:0]  duty_pct;
   logic        meas_done;
   logic        sig_valid;
   logic        overrun;

   pwm_capture #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
      .period_cyc(period_cyc), .high_cyc(high_cyc), .freq_hz(freq_hz), .duty_pct(duty_pct),
      .meas_done(meas_done), .sig_valid(sig_valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint      cyc;
      int unsigned per;
      int unsigned hi;
      int unsigned frq;
      int unsigned dty;
      bit          vld;
   } meas_t;

   longint cyc = 0;
   longint rise_q[$];
   meas_t  meas_q[$];
   int     ovr_cnt = 0;
   int     n_checks = 0;
   int     n_fail = 0;

   int gen_per = 0;
   int gen_high = 0;
   int gen_left = 0;
   bit gen_busy = 1'b0;
   int gp;
   int gh;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (meas_done === 1'b1)
         meas_q.push_back('{cyc, int'(period_cyc), int'(high_cyc), int'(freq_hz), int'(duty_pct), sig_valid});
      if (overrun === 1'b1) ovr_cnt++;
   end

   // Each period starts just after a posedge. The signal is high for gh cycles out of gp.
   initial begin : gen
      pwm_in = 1'b0;
      forever begin
         @(posedge clk);
         if (gen_left > 0) begin
            gen_busy = 1'b1;
            gp = gen_per;
            gh = gen_high;
            #1 pwm_in = 1'b1;
            rise_q.push_back(cyc);
            repeat (gh) @(posedge clk);
            #1 pwm_in = 1'b0;
            repeat (gp - gh - 1) @(posedge clk);
            gen_left = gen_left - 1;
            if (gen_left <= 0) gen_busy = 1'b0;
         end
      end
   end

   task automatic wait_gen_idle(input int bound, input string name);
      int n = 0;
      while ((gen_left > 0 || gen_busy) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (gen_left > 0 || gen_busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s generator_wait: still busy after %0d cycles", name, bound);
      end
   endtask

   task automatic do_reset();
      wait_gen_idle(20000, "do_reset");
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // A snapshot occurs on every rising edge except the first one after idle.
   // The compute engine is busy for 66 cycles after it accepts a snapshot; snapshots arriving meanwhile are dropped.
   task automatic check_run(input int p, input int h, input string name);
      longint exp_cyc[$];
      longint last_acc = 0;
      bit     have_acc = 1'b0;
      int     exp_ovr = 0;
      int unsigned e_frq = CLK_HZ / p;
      int unsigned e_dty = (h * 100) / p;
      for (int i = 1; i < rise_q.size(); i++) begin
         if (!have_acc || rise_q[i] > last_acc + 66) begin
            exp_cyc.push_back(rise_q[i] + LAT);
            last_acc = rise_q[i];
            have_acc = 1'b1;
         end else begin
            exp_ovr++;
         end
      end
      n_checks++;
      if (meas_q.size() !== exp_cyc.size()) begin
         n_fail++;
         $display("FAIL %s meas_count: got %0d expected %0d", name, meas_q.size(), exp_cyc.size());
      end
      for (int i = 0; i < meas_q.size() && i < exp_cyc.size(); i++) begin
         n_checks++;
         if (meas_q[i].cyc !== exp_cyc[i]) begin
            n_fail++;
            $display("FAIL %s meas_time[%0d]: got cycle %0d expected %0d", name, i, meas_q[i].cyc, exp_cyc[i]);
         end
         n_checks++;
         if (meas_q[i].per !== p || meas_q[i].hi !== h) begin
            n_fail++;
            $display("FAIL %s counts[%0d]: got period %0d high %0d expected %0d %0d",
                     name, i, meas_q[i].per, meas_q[i].hi, p, h);
         end
         n_checks++;
         if (meas_q[i].frq !== e_frq || meas_q[i].dty !== e_dty) begin
            n_fail++;
            $display("FAIL %s quotients[%0d]: got freq %0d duty %0d expected %0d %0d",
                     name, i, meas_q[i].frq, meas_q[i].dty, e_frq, e_dty);
         end
         n_checks++;
         if (meas_q[i].vld !== 1'b1) begin
            n_fail++;
            $display("FAIL %s sig_valid[%0d]: got %0b expected 1", name, i, meas_q[i].vld);
         end
      end
      n_checks++;
      if (ovr_cnt !== exp_ovr) begin
         n_fail++;
         $display("FAIL %s overrun_count: got %0d expected %0d", name, ovr_cnt, exp_ovr);
      end
   endtask

   task automatic run_and_check(input int p, input int h, input int k, input string name);
      @(posedge clk);
      rise_q.delete();
      meas_q.delete();
      ovr_cnt = 0;
      gen_per = p;
      gen_high = h;
      gen_left = k;
      wait_gen_idle(k * p + 100, name);
      repeat (80) @(negedge clk);
      check_run(p, h, name);
      if (meas_q.size() > 0) begin
         n_checks++;
         if (period_cyc !== meas_q[$].per[23:0] || high_cyc !== meas_q[$].hi[23:0] ||
             freq_hz !== meas_q[$].frq[23:0] || duty_pct !== meas_q[$].dty[6:0] || sig_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold: got %0d %0d %0d %0d v=%0b expected last written %0d %0d %0d %0d v=1",
                     name, period_cyc, high_cyc, freq_hz, duty_pct, sig_valid,
                     meas_q[$].per, meas_q[$].hi, meas_q[$].frq, meas_q[$].dty);
         end
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if (period_cyc !== 24'd0 || high_cyc !== 24'd0 || freq_hz !== 24'd0 || duty_pct !== 7'd0) begin
         n_fail++;
         $display("FAIL %s results: got %0d %0d %0d %0d expected all 0", name, period_cyc, high_cyc, freq_hz, duty_pct);
      end
      n_checks++;
      if (sig_valid !== 1'b0 || meas_done !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL %s flags: got valid=%0b done=%0b ovr=%0b expected 0 0 0", name, sig_valid, meas_done, overrun);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("after_release");
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++) begin
         int p = int'($urandom_range(1200, 3));
         int h = int'($urandom_range(p - 1, 1));
         do_reset();
         run_and_check(p, h, 4, $sformatf("random_%0d_p%0d_h%0d", i, p, h));
      end
   endtask

   task automatic test_timeout();
      longint r;
      do_reset();
      run_and_check(1000, 500, 3, "pre_timeout");
      r = rise_q[$];
      while (cyc < r + 2 + TIMEOUT) @(negedge clk);
      n_checks++;
      if (sig_valid !== 1'b1 || period_cyc !== 24'd1000) begin
         n_fail++;
         $display("FAIL timeout_early: got valid=%0b period=%0d expected 1 1000", sig_valid, period_cyc);
      end
      @(negedge clk);
      check_zero("timeout");
      n_checks++;
      if (meas_q.size() !== 2) begin
         n_fail++;
         $display("FAIL timeout_no_done: got %0d meas_done expected 2", meas_q.size());
      end
      run_and_check(300, 199, 4, "restart_after_timeout");
   endtask

   task automatic test_reset_mid_div();
      int     n = 0;
      int     k;
      int     m;
      longint r;
      do_reset();
      @(posedge clk);
      rise_q.delete();
      meas_q.delete();
      ovr_cnt = 0;
      gen_per = 1000;
      gen_high = 500;
      gen_left = 100;
      while (meas_q.size() < 2 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      k = rise_q.size();
      n = 0;
      while (rise_q.size() <= k && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (meas_q.size() < 2 || rise_q.size() <= k) begin
         n_fail++;
         $display("FAIL reset_mid_div setup: got %0d meas_done expected 2", meas_q.size());
         gen_left = 0;
         return;
      end
      r = rise_q[k];
      while (cyc < r + 34) @(negedge clk);
      n_checks++;
      if (period_cyc !== 24'd1000 || sig_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_div before: got period=%0d valid=%0b expected 1000 1", period_cyc, sig_valid);
      end
      m = meas_q.size();
      rst_n = 1'b0;
      #1;
      check_zero("reset_mid_div_immediate");
      while (cyc < r + 600) @(negedge clk);
      n_checks++;
      if (meas_q.size() !== m) begin
         n_fail++;
         $display("FAIL reset_mid_div no_done: got %0d meas_done expected %0d", meas_q.size(), m);
      end
      rst_n = 1'b1;
      rise_q.delete();
      meas_q.delete();
      ovr_cnt = 0;
      gen_left = 4;
      wait_gen_idle(5000, "reset_mid_div");
      repeat (80) @(negedge clk);
      check_run(1000, 500, "reset_mid_div_restart");
   endtask

   initial begin
      test_reset();
      do_reset();
      run_and_check(5000, 4950, 3, "f200_d99");
      do_reset();
      run_and_check(1000, 500, 6, "f1k_d50");
      do_reset();
      run_and_check(300, 199, 5, "truncation");
      do_reset();
      run_and_check(40, 20, 12, "overrun");
      test_random();
      test_timeout();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning clk frequency in Hz (32-bit).
REQ-002 SHALL have parameter TIMEOUT, default 10_000_000, meaning the no-edge limit in clk cycles (24-bit, 200 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit, system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in, input, 1 bit, external PWM signal, asynchronous to clk.
REQ-006 SHALL have port period_cyc, output, 24 bits, last measured period in clk cycles.
REQ-007 SHALL have port high_cyc, output, 24 bits, last measured high time in clk cycles.
REQ-008 SHALL have port freq_hz, output, 24 bits, equal to floor(CLK_HZ / period_cyc).
REQ-009 SHALL have port duty_pct, output, 7 bits, equal to floor(high_cyc*100 / period_cyc), range 0..99.
REQ-010 SHALL have port meas_done, output, 1 bit, one-cycle pulse when all four result outputs update.
REQ-011 SHALL have port sig_valid, output, 1 bit, high while the results reflect a live signal.
REQ-012 SHALL have port overrun, output, 1 bit, one-cycle pulse when a snapshot is dropped.

Function
REQ-013 SHALL pass pwm_in through a 2-flop synchronizer plus 1 history flop, and detect rising and falling edges on the synchronized signal.
REQ-014 Edge detection SHALL have a constant latency, so the counts for a stable input are exact.
REQ-015 Capture FSM SHALL have the states S_IDLE, S_HIGH and S_LOW, with S_IDLE as the reset state.
REQ-016 S_IDLE SHALL go to S_HIGH on a rising edge, clearing the period counter and the high counter to 1.
REQ-017 S_HIGH SHALL increment both counters each cycle and go to S_LOW on a falling edge, freezing the high counter.
REQ-018 S_LOW SHALL increment the period counter each cycle.
REQ-019 On a rising edge in S_LOW, the FSM SHALL snapshot (period, high), restart both counters at 1 and go to S_HIGH.
REQ-020 The first rising edge after S_IDLE SHALL NOT produce a snapshot; the first snapshot occurs on the second rising edge.
REQ-021 Period count SHALL equal the number of clk cycles between consecutive rising edges; high count SHALL equal the cycles from a rising edge to the following falling edge.
REQ-022 Timeout: if the period counter reaches TIMEOUT in S_HIGH or S_LOW, the FSM SHALL go to S_IDLE and set sig_valid=0.
REQ-023 On timeout, period_cyc, high_cyc, freq_hz and duty_pct SHALL all be set to 0, with no meas_done and any in-progress division aborted.
REQ-024 A constant-high or constant-low input SHALL therefore time out and SHALL never produce 100% or 0% duty.
REQ-025 Compute FSM SHALL have the states C_IDLE, C_LOAD, C_FREQ, C_DUTY and C_WRITE, using one shared sequential restoring divider.
REQ-026 The divider SHALL take a 32-bit dividend and a 24-bit divisor and produce 1 quotient bit per cycle over 32 cycles.
REQ-027 C_FREQ SHALL divide CLK_HZ by the snapshot period.
REQ-028 C_DUTY SHALL divide snapshot_high*100 (31 bits, no overflow) by the snapshot period.
REQ-029 Quotients SHALL be truncated and never rounded.
REQ-030 All four result outputs SHALL update together in C_WRITE, with meas_done and sig_valid=1 asserted in the same cycle.
REQ-031 C_WRITE SHALL occur exactly 66 cycles after the snapshot cycle (1 load + 32 + 32 + 1 write).
REQ-032 Result outputs SHALL hold their values between writes.
REQ-033 A snapshot arriving while the compute FSM is not in C_IDLE SHALL be discarded, with overrun pulsed for 1 cycle, while the current computation completes unaffected.
REQ-034 A snapshot arriving in the same cycle as C_WRITE SHALL be discarded with an overrun pulse.
REQ-035 Counters SHALL never wrap, because TIMEOUT does not exceed 2^24-1.

Reset
REQ-036 While rst_n=0, period_cyc, high_cyc, freq_hz and duty_pct SHALL be 0, and meas_done, sig_valid and overrun SHALL be 0.
REQ-037 While rst_n=0, the capture FSM SHALL be S_IDLE, the compute FSM SHALL be C_IDLE, and the synchronizer SHALL be 0.
REQ-038 Reset asserted mid-measurement or mid-division SHALL clear all state immediately (asynchronously), with no meas_done on release.
REQ-039 After release, the first meas_done SHALL occur only after two rising edges plus 66 cycles.

Verification
REQ-040 Bench SHALL drive 200 Hz, 99% duty (period 250000, high 247500) -> period_cyc=250000, high_cyc=247500, freq_hz=200, duty_pct=99, sig_valid=1.
REQ-041 Bench SHALL drive 1 kHz, 50% duty (period 50000, high 25000) -> freq_hz=1000, duty_pct=50, meas_done once per period, 66 cycles after each snapshot.
REQ-042 Bench SHALL drive period 300, high 199 -> freq_hz=166666, duty_pct=66 (truncation).
REQ-043 Bench SHALL hold pwm_in low for TIMEOUT cycles after a valid signal -> sig_valid=0 and all results 0, then on restart the first meas_done follows the second rising edge.
REQ-044 Bench SHALL drive period 40, high 20 -> overrun pulses on dropped snapshots, and every meas_done still shows period_cyc=40, duty_pct=50.
REQ-045 Bench SHALL pulse rst_n low 30 cycles into C_FREQ -> outputs 0 immediately, no meas_done, and the measurement restarts correctly afterward.
